instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Main processor state machine: sequences the fetch and execute phases and drives the 6-bit `state` code consumed by `control_unit`, which turns each state into a 20-bit control word. It decodes the opcode held in the instruction register at the end of fetch and steps through the matching execute states. It also reports run status and counts completed instructions.

## Interface
- `OPW`, default 8: opcode width.
- `CNT_W`, default 16: width of the completed-instruction counter.
- `clock`  in  1: single clock. All logic updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: level, sampled every cycle. Takes effect only in IDLE.
- `hold`  in  1: freezes the sequencer while high.
- `opcode`  in  OPW: instruction-register opcode. Valid while `state`=FETCH6.
- `state`  out  6: registered current state code.
- `busy`  out  1: registered. High whenever `state`≠IDLE.
- `done`  out  1: registered one-cycle pulse on END completion.
- `illegal_op`  out  1: registered, sticky. Set when an unknown opcode is decoded.
- `instr_count`  out  CNT_W: registered count of completed legal instructions. Saturates at all-ones.

## Operation
- State codes:
  - IDLE=0
  - FETCH1..FETCH6=1..6
  - LDR11..LDR14=7..10
  - LDR21..LDR24=11..14
  - STAC1..STAC4=15..18
  - ADD=19, ADD2=20
  - MUL=21
  - Codes 22–63 are unused.
- Opcodes: LDR1=8'h01, LDR2=8'h02, STAC=8'h03, ADD=8'h04, MUL=8'h05, END=8'hFF.
- Transitions (when not held):
  - IDLE→FETCH1 if `start`=1. Otherwise stay in IDLE.
  - FETCHn→FETCHn+1 for n=1..5.
  - FETCH6 branches on `opcode`:
    - LDR1→LDR11, LDR2→LDR21, STAC→STAC1, ADD→ADD, MUL→MUL.
    - END→IDLE.
    - Any other value→FETCH1 and set `illegal_op`.
  - LDRx1→LDRx2→LDRx3→LDRx4→FETCH1.
  - STAC1→STAC2→STAC3→STAC4→FETCH1.
  - ADD→ADD2→FETCH1.
  - MUL→FETCH1.
  - Any unused code→IDLE on the next cycle (recovery).
- `instr_count` increments on each transition into FETCH1 from LDR14, LDR24, STAC4, ADD2 or MUL. It holds at 2^CNT_W−1.
- `illegal_op` clears on reset, or on the cycle `start` is accepted in IDLE.
- `done`:
  - Asserts in the first cycle with `state`=IDLE after END is decoded.
  - Stays low otherwise, including after reset.
- Priority, highest first:
  1. `reset`
  2. `hold`: `state`, `instr_count` and `illegal_op` are frozen; `done` is forced to 0.
  3. Normal transitions.
- Because `hold` outranks `start`, a `start` asserted in IDLE while `hold`=1 is not accepted.

## Timing
- Reset values: `state`=0, `busy`=0, `done`=0, `illegal_op`=0, `instr_count`=0.
- Reset mid-instruction:
  - Next cycle, `state`=IDLE and the counter is 0.
  - No `done` pulse is produced.
- Latency from `start` sampled at edge k:
  - `state`=1 after edge k.
  - `opcode` is sampled at the edge that leaves FETCH6, 6 cycles later.
- Cycles per instruction, FETCH1 through return to FETCH1:
  - LDR1, LDR2, STAC: 10.
  - ADD: 8.
  - MUL: 7.
  - END: 6 cycles, then IDLE.
- `control_unit` registers its output, so the control word lags `state` by one cycle. Any consumer of `busy`/`state` must account for this.
- `busy` is derived from next-state and registered, so it is aligned with `state`.

## Structure
- Shared package `proc_pkg` holds:
  - the 6-bit state code localparams (shared with `control_unit`);
  - the opcode localparams.
- Sub-module `opcode_decode` is combinational:
  - maps `opcode` to the first execute state code;
  - provides `is_end` and `is_illegal`.
- The sequencer holds only the state register, next-state logic, counter and flags.

## Test plan
- Reset and idle:
  - Hold `reset` for 3 cycles with `start`=1 → `state`=0, `busy`=0, `instr_count`=0.
  - Release reset with `start`=1 → `state`=1 next cycle.
- LDR1 then END (`opcode`=8'h01 at first FETCH6, 8'hFF at second):
  - `state` sequence 1..6, 7..10, 1..6, 0.
  - `done`=1 for exactly 1 cycle when `state` returns to 0.
  - `instr_count`=1.
- ADD, then MUL, then END:
  - ADD step is 19→20→1; MUL step is 21→1.
  - `instr_count`=2 at END.
- Illegal opcode 8'h3C:
  - FETCH6→FETCH1; `illegal_op`=1 and stays set.
  - `instr_count` is unchanged.
  - The next `start` from IDLE clears `illegal_op`.
- Hold and reset mid-instruction:
  - `hold`=1 for 4 cycles at STAC2 → `state` stays 16, then continues to 17.
  - Assert `reset` at LDR23 → `state`=0 next cycle, `done`=0.
- Counter saturation with CNT_W=2:
  - Run 5 MUL instructions → `instr_count` sticks at 3.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared processor definitions: 6-bit sequencer state codes (also decoded by
// control_unit) and the instruction opcodes.
package proc_pkg;

   typedef logic [5:0] state_t;

   localparam state_t S_IDLE   = 6'd0;
   localparam state_t S_FETCH1 = 6'd1;
   localparam state_t S_FETCH2 = 6'd2;
   localparam state_t S_FETCH3 = 6'd3;
   localparam state_t S_FETCH4 = 6'd4;
   localparam state_t S_FETCH5 = 6'd5;
   localparam state_t S_FETCH6 = 6'd6;
   localparam state_t S_LDR11  = 6'd7;
   localparam state_t S_LDR12  = 6'd8;
   localparam state_t S_LDR13  = 6'd9;
   localparam state_t S_LDR14  = 6'd10;
   localparam state_t S_LDR21  = 6'd11;
   localparam state_t S_LDR22  = 6'd12;
   localparam state_t S_LDR23  = 6'd13;
   localparam state_t S_LDR24  = 6'd14;
   localparam state_t S_STAC1  = 6'd15;
   localparam state_t S_STAC2  = 6'd16;
   localparam state_t S_STAC3  = 6'd17;
   localparam state_t S_STAC4  = 6'd18;
   localparam state_t S_ADD    = 6'd19;
   localparam state_t S_ADD2   = 6'd20;
   localparam state_t S_MUL    = 6'd21;

   localparam logic [7:0] OP_LDR1 = 8'h01;
   localparam logic [7:0] OP_LDR2 = 8'h02;
   localparam logic [7:0] OP_STAC = 8'h03;
   localparam logic [7:0] OP_ADD  = 8'h04;
   localparam logic [7:0] OP_MUL  = 8'h05;
   localparam logic [7:0] OP_END  = 8'hFF;

endpackage

// File: rtl/opcode_decode.sv
// Combinational opcode decode: first execute state for the opcode, plus
// END and illegal-opcode flags.
module opcode_decode
   import proc_pkg::*;
#(
   parameter int OPW = 8
) (
   input  logic [OPW-1:0] opcode,
   output logic [5:0]     first_state,
   output logic           is_end,
   output logic           is_illegal
);

   always_comb begin
      first_state = S_IDLE;
      is_end      = 1'b0;
      is_illegal  = 1'b0;
      if (opcode == OPW'(OP_LDR1))      first_state = S_LDR11;
      else if (opcode == OPW'(OP_LDR2)) first_state = S_LDR21;
      else if (opcode == OPW'(OP_STAC)) first_state = S_STAC1;
      else if (opcode == OPW'(OP_ADD))  first_state = S_ADD;
      else if (opcode == OPW'(OP_MUL))  first_state = S_MUL;
      else if (opcode == OPW'(OP_END))  is_end      = 1'b1;
      else                              is_illegal  = 1'b1;
   end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/execute sequencer: owns the state register, next-state logic, the
// saturating completed-instruction counter and the run-status flags.
module instr_sequencer
   import proc_pkg::*;
#(
   parameter int OPW   = 8,
   parameter int CNT_W = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             hold,
   input  logic [OPW-1:0]   opcode,
   output logic [5:0]       state,
   output logic             busy,
   output logic             done,
   output logic             illegal_op,
   output logic [CNT_W-1:0] instr_count
);

   state_t           next_state;
   logic             cnt_inc, set_ill, clr_ill, end_hit;
   logic             busy_d, done_d, illegal_d;
   logic [CNT_W-1:0] count_d;
   logic [5:0]       dec_first;
   logic             dec_end, dec_illegal;

   opcode_decode #(.OPW(OPW)) u_decode (
      .opcode      (opcode),
      .first_state (dec_first),
      .is_end      (dec_end),
      .is_illegal  (dec_illegal)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= S_IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         illegal_op  <= 1'b0;
         instr_count <= '0;
      end else begin
         state       <= next_state;
         busy        <= busy_d;
         done        <= done_d;
         illegal_op  <= illegal_d;
         instr_count <= count_d;
      end
   end

   // hold leaves every event flag low, so state, counter and flags freeze.
   always_comb begin
      next_state = state;
      cnt_inc    = 1'b0;
      set_ill    = 1'b0;
      clr_ill    = 1'b0;
      end_hit    = 1'b0;
      if (!hold) begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  next_state = S_FETCH1;
                  clr_ill    = 1'b1;
               end
            end
            S_FETCH1, S_FETCH2, S_FETCH3, S_FETCH4, S_FETCH5,
            S_LDR11, S_LDR12, S_LDR13, S_LDR21, S_LDR22, S_LDR23,
            S_STAC1, S_STAC2, S_STAC3, S_ADD:
               next_state = state + 6'd1;
            S_FETCH6: begin
               if (dec_end) begin
                  next_state = S_IDLE;
                  end_hit    = 1'b1;
               end else if (dec_illegal) begin
                  next_state = S_FETCH1;
                  set_ill    = 1'b1;
               end else begin
                  next_state = dec_first;
               end
            end
            S_LDR14, S_LDR24, S_STAC4, S_ADD2, S_MUL: begin
               next_state = S_FETCH1;
               cnt_inc    = 1'b1;
            end
            default: next_state = S_IDLE;
         endcase
      end
   end

   always_comb begin
      busy_d    = (next_state != S_IDLE);
      done_d    = end_hit;
      illegal_d = illegal_op;
      if (clr_ill)      illegal_d = 1'b0;
      else if (set_ill) illegal_d = 1'b1;
      count_d = instr_count;
      if (cnt_inc && (instr_count != {CNT_W{1'b1}}))
         count_d = instr_count + CNT_W'(1);
   end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: an instruction-level model expands each
// opcode into its expected state trace; both a 16-bit and a 2-bit counter build run.
module tb_instr_sequencer;

   logic        clock, reset, start, hold;
   logic [7:0]  opcode;
   logic [5:0]  state_a, state_b;
   logic        busy_a, busy_b, done_a, done_b, ill_a, ill_b;
   logic [15:0] cnt_a;
   logic [1:0]  cnt_b;

   int checks = 0;
   int errors = 0;

   // Expected entry: {state, busy, done, illegal, count16, count2}
   logic [26:0] exp_q[$];
   logic [15:0] m_cnt;
   logic [1:0]  m_cnt2;
   logic        m_ill;

   instr_sequencer #(.OPW(8), .CNT_W(16)) dut (
      .clock(clock), .reset(reset), .start(start), .hold(hold), .opcode(opcode),
      .state(state_a), .busy(busy_a), .done(done_a), .illegal_op(ill_a),
      .instr_count(cnt_a)
   );

   instr_sequencer #(.OPW(8), .CNT_W(2)) dut_sat (
      .clock(clock), .reset(reset), .start(start), .hold(hold), .opcode(opcode),
      .state(state_b), .busy(busy_b), .done(done_b), .illegal_op(ill_b),
      .instr_count(cnt_b)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clock) begin
      if (exp_q.size() > 0) begin
         logic [26:0] e;
         e = exp_q.pop_front();
         chk("state",      32'(state_a), 32'(e[26:21]));
         chk("busy",       32'(busy_a),  32'(e[20]));
         chk("done",       32'(done_a),  32'(e[19]));
         chk("illegal_op", 32'(ill_a),   32'(e[18]));
         chk("count",      32'(cnt_a),   32'(e[17:2]));
         chk("sat_state",  32'(state_b), 32'(e[26:21]));
         chk("sat_busy",   32'(busy_b),  32'(e[20]));
         chk("sat_done",   32'(done_b),  32'(e[19]));
         chk("sat_ill",    32'(ill_b),   32'(e[18]));
         chk("sat_count",  32'(cnt_b),   32'(e[1:0]));
      end
   end

   // One clock: record what the outputs must show after this edge, then advance.
   task automatic step(input logic [5:0] s, input logic d);
      exp_q.push_back({s, (s != 6'd0), d, m_ill, m_cnt, m_cnt2});
      @(posedge clock);
      #1;
   endtask

   task automatic model_reset();
      m_cnt  = '0;
      m_cnt2 = '0;
      m_ill  = 1'b0;
   endtask

   task automatic model_complete();
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (m_cnt2 != 2'b11)   m_cnt2 = m_cnt2 + 2'd1;
   endtask

   task automatic begin_run();
      start = 1'b1;
      m_ill = 1'b0;
      step(6'd1, 1'b0);
      start = 1'b0;
   endtask

   // Runs FETCH2..FETCH6 and the execute phase of one instruction; entered in FETCH1.
   task automatic exec(input logic [7:0] op);
      int base;
      int len;
      opcode = op;
      for (int s = 2; s <= 6; s++) step(6'(s), 1'b0);
      case (op)
         8'h01:   begin base = 7;  len = 4; end
         8'h02:   begin base = 11; len = 4; end
         8'h03:   begin base = 15; len = 4; end
         8'h04:   begin base = 19; len = 2; end
         8'h05:   begin base = 21; len = 1; end
         default: begin base = 0;  len = 0; end
      endcase
      if (len > 0) begin
         for (int i = 0; i < len; i++) step(6'(base + i), 1'b0);
         model_complete();
         step(6'd1, 1'b0);
      end else if (op == 8'hFF) begin
         step(6'd0, 1'b1);
      end else begin
         m_ill = 1'b1;
         step(6'd1, 1'b0);
      end
   endtask

   initial begin
      reset  = 1'b1;
      start  = 1'b1;
      hold   = 1'b0;
      opcode = 8'h00;
      model_reset();

      // Reset held with start high, then released with start still high.
      repeat (3) step(6'd0, 1'b0);
      reset = 1'b0;
      begin_run();

      // LDR1 then END.
      exec(8'h01);
      exec(8'hFF);
      chk("lit_ldr1_count", 32'(cnt_a), 32'd1);
      chk("lit_ldr1_done",  32'(done_a), 32'd1);
      step(6'd0, 1'b0);

      // ADD, MUL, END from a fresh reset.
      reset = 1'b1;
      model_reset();
      step(6'd0, 1'b0);
      reset = 1'b0;
      begin_run();
      exec(8'h04);
      exec(8'h05);
      exec(8'hFF);
      chk("lit_addmul_count", 32'(cnt_a), 32'd2);

      // Illegal opcode: sticky flag, count unchanged, cleared by next start.
      begin_run();
      exec(8'h3C);
      chk("lit_illegal_set", 32'(ill_a), 32'd1);
      exec(8'hFF);
      step(6'd0, 1'b0);
      begin_run();
      chk("lit_illegal_clr", 32'(ill_a), 32'd0);
      chk("lit_illegal_cnt", 32'(cnt_a), 32'd2);
      exec(8'hFF);

      // start is ignored while hold is high in IDLE.
      hold  = 1'b1;
      start = 1'b1;
      step(6'd0, 1'b0);
      step(6'd0, 1'b0);
      hold = 1'b0;
      m_ill = 1'b0;
      step(6'd1, 1'b0);
      start = 1'b0;

      // STAC with a 4-cycle hold at STAC2.
      opcode = 8'h03;
      for (int s = 2; s <= 6; s++) step(6'(s), 1'b0);
      step(6'd15, 1'b0);
      step(6'd16, 1'b0);
      hold = 1'b1;
      repeat (4) step(6'd16, 1'b0);
      hold = 1'b0;
      step(6'd17, 1'b0);
      step(6'd18, 1'b0);
      model_complete();
      step(6'd1, 1'b0);

      // Reset at LDR23.
      opcode = 8'h02;
      for (int s = 2; s <= 6; s++) step(6'(s), 1'b0);
      step(6'd11, 1'b0);
      step(6'd12, 1'b0);
      step(6'd13, 1'b0);
      reset = 1'b1;
      model_reset();
      step(6'd0, 1'b0);
      reset = 1'b0;
      step(6'd0, 1'b0);
      chk("lit_reset_state", 32'(state_a), 32'd0);

      // Five MULs: the 2-bit counter saturates at 3.
      begin_run();
      repeat (5) exec(8'h05);
      chk("lit_sat_count2", 32'(cnt_b), 32'd3);
      chk("lit_sat_count16", 32'(cnt_a), 32'd5);
      exec(8'hFF);

      repeat (2) @(negedge clock);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
